// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store port between CPU datapath and data memory responder
//
// Purpose: groups the request/response signals of the data-memory port.
// Ports:
//   mem_read, mem_write   request strobes, held until mem_ready
//   mem_addr[31:0]        byte address
//   write_data[31:0]      right-aligned store data
//   funct3[2:0]           RV32 access size code
//   mem_data[31:0]        load result
//   mem_ready             one-cycle response strobe
//   mem_fault             error qualifier, valid with mem_ready
//   busy                  responder not idle
// Modports: master (requester side), slave (responder side).

interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        mem_fault;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_addr, write_data, funct3,
    input  mem_data, mem_ready, mem_fault, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, write_data, funct3,
    output mem_data, mem_ready, mem_fault, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data RAM behind the CPU load/store port
//
// Purpose: accepts load/store requests, waits WAIT_CYCLES, commits the access
// on the edge entering RESP and pulses mem_ready for one cycle. Misaligned,
// out-of-range and malformed accesses respond with mem_fault and no RAM write.
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       data_mem_responder_if.slave (request in, response out)
// Parameters:
//   DEPTH        number of 32-bit words (word index = mem_addr[31:2]), >= 2
//   WAIT_CYCLES  wait states between acceptance and response (0..15)

module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  data_mem_responder_if.slave bus
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]    wait_cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic          store_q;
  logic          fault_q;
  logic [31:0]   mem_data_q;

  logic [31:0]   ram [DEPTH];

  logic          req;
  logic          accept;
  logic          in_fault;
  logic          commit;

  assign req    = bus.mem_read | bus.mem_write;
  assign accept = (state == IDLE) && req;

  // Fault decode on the live request; latched at acceptance.
  always_comb begin
    in_fault = 1'b0;
    if (bus.mem_read && bus.mem_write) begin
      in_fault = 1'b1;
    end
    case (bus.funct3)
      3'd0: in_fault = in_fault;
      3'd1: if (bus.mem_addr[0]) in_fault = 1'b1;
      3'd2: if (bus.mem_addr[1:0] != 2'b00) in_fault = 1'b1;
      3'd4: if (bus.mem_write) in_fault = 1'b1;
      3'd5: if (bus.mem_write || bus.mem_addr[0]) in_fault = 1'b1;
      default: in_fault = 1'b1;
    endcase
    if ({2'b00, bus.mem_addr[31:2]} >= DEPTH_W) begin
      in_fault = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The commit edge is the one entering RESP. With no wait states that is the
  // accepting edge itself, so the access is taken straight from the bus.
  assign commit = (state_next == RESP) && (state != RESP);

  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [2:0]    cur_f3;
  logic          cur_store;
  logic          cur_fault;
  logic [AW-1:0] cur_idx;

  always_comb begin
    if (state == IDLE) begin
      cur_addr  = bus.mem_addr[AW+1:0];
      cur_wdata = bus.write_data;
      cur_f3    = bus.funct3;
      cur_store = bus.mem_write;
      cur_fault = in_fault;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = funct3_q;
      cur_store = store_q;
      cur_fault = fault_q;
    end
  end

  assign cur_idx = cur_addr[AW+1:2];

  // Request latch and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      fault_q  <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      if (accept) begin
        addr_q   <= bus.mem_addr[AW+1:0];
        wdata_q  <= bus.write_data;
        funct3_q <= bus.funct3;
        store_q  <= bus.mem_write;
        fault_q  <= in_fault;
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Store path: little-endian lanes, data shifted up from the right-aligned input.
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic        ram_we;

  assign wdata_lane = cur_wdata << {cur_addr[1:0], 3'b000};

  always_comb begin
    byte_en = 4'b0000;
    case (cur_f3)
      3'd0:    byte_en = 4'b0001 << cur_addr[1:0];
      3'd1:    byte_en = 4'b0011 << {cur_addr[1], 1'b0};
      3'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // reset_n gating keeps a store aborted by reset from landing on the next edge.
  assign ram_we = commit && cur_store && !cur_fault && reset_n;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          ram[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

  // Load path: shift the selected lane(s) down, then extend.
  logic [31:0] rd_word;
  logic [15:0] rd_lane;
  logic [31:0] load_val;

  assign rd_word = ram[cur_idx];
  assign rd_lane = 16'(rd_word >> {cur_addr[1:0], 3'b000});

  always_comb begin
    load_val = 32'd0;
    case (cur_f3)
      3'd0:    load_val = {{24{rd_lane[7]}}, rd_lane[7:0]};
      3'd1:    load_val = {{16{rd_lane[15]}}, rd_lane};
      3'd2:    load_val = rd_word;
      3'd4:    load_val = {24'd0, rd_lane[7:0]};
      3'd5:    load_val = {16'd0, rd_lane};
      default: load_val = 32'd0;
    endcase
  end

  // mem_data holds between loads; store responses leave it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_data_q <= 32'd0;
    end else if (commit && !cur_store) begin
      mem_data_q <= cur_fault ? 32'd0 : load_val;
    end
  end

  assign bus.mem_data  = mem_data_q;
  assign bus.mem_ready = (state == RESP);
  assign bus.mem_fault = (state == RESP) && fault_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder that sits on the far side of the CPU datapath's load/store port.
- Accepts mem_read/mem_write requests with address, store data and access size, and services them from an internal word-organised RAM with a programmable wait-state count.
- Returns load data sign- or zero-extended, with a one-cycle mem_ready pulse.
- Flags misaligned, out-of-range and malformed accesses via mem_fault.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM; word index = mem_addr[31:2].
- WAIT_CYCLES, 1, extra wait states between request acceptance and response (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request, held by the requester until mem_ready.
- mem_write  in  1  store request, held by the requester until mem_ready.
- mem_addr  in  32  byte address.
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- funct3  in  3  RV32 size code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- mem_data  out  32  load result.
- mem_ready  out  1  one-cycle response strobe.
- mem_fault  out  1  error qualifier, valid only with mem_ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_data=0, mem_ready=0, mem_fault=0, busy=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset during WAIT aborts the access; a pending store is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write at a rising edge: latch addr, write_data, funct3, op; compute fault.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counts WAIT_CYCLES cycles, then goes to RESP.
- Commit edge: the edge entering RESP.
  - Store: RAM byte lanes are written here, and only if fault=0.
  - Load: mem_data is registered here.
- RESP: mem_ready=1 and mem_fault=fault for exactly one cycle, then IDLE.
- Latency: mem_ready is high in cycle WAIT_CYCLES+1 after the accepting edge.
- Request inputs are ignored outside IDLE.
- A request still asserted in IDLE after RESP is accepted as a new request. The requester deasserts on the edge that ends RESP.
- Fault conditions (any):
  - mem_read & mem_write both high.
  - funct3 in {3,6,7}; for stores, funct3 in {4,5} also faults.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
- On fault: no RAM write, mem_data=0.
- Byte lanes are little-endian.
  - SB writes lane addr[1:0] with write_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with write_data[15:0].
  - SW writes all four lanes.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane(s).
  - LBU/LHU zero-extend.
  - LW returns the full word.
- mem_data holds its value between responses. It is updated only at a load's commit edge, or cleared to 0 on a faulting load.
- Store responses leave mem_data unchanged.
- busy=1 in WAIT and RESP.

Test Plan:
1. WAIT_CYCLES=1: SW 0x00000005 @0, then LW @0 → mem_ready 2 cycles after each acceptance; mem_data=0x00000005, mem_fault=0.
2. After test 1: SB 0x80 @3 → LB @3 gives 0xFFFFFF80, LBU @3 gives 0x00000080, LW @0 gives 0x80000005.
3. SH 0xBEEF @6 → LH @6 gives 0xFFFFBEEF, LHU @6 gives 0x0000BEEF. LH @1 → mem_ready with mem_fault=1, mem_data=0; LW @0 still 0x80000005.
4. LW @4*DEPTH, SW @2, mem_read=mem_write=1, and funct3=3 → each gives mem_fault=1 with mem_ready; follow-up loads show no RAM change.
5. SW 0x12345678 @8, then pull reset_n low during WAIT → outputs 0 immediately, busy=0; after release, LW @8 returns the previous contents (not 0x12345678).
6. WAIT_CYCLES=0: back-to-back SW/LW with requester dropping request on the ready edge → mem_ready in the cycle after each acceptance, no duplicate acceptance, correct data.
